// File: rtl/vga_timing_compositor.sv
// vga_timing_compositor: 640x480 VGA raster timing with overlay/background compositing.
//   clk, rst_n (async active-low), pix_en (pixel strobe)
//   overlay_rgb/bg_rgb  : 6-bit {R1R0,G1G0,B1B0} overlay and background colours
//   x, y, active        : combinational raster position fed to overlay generators
//   rgb_out, hsync, vsync, frame_start : registered, mutually aligned outputs
//   frame_count         : completed-frame counter, wraps at 256
module vga_timing_compositor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT = 16,
    parameter int H_SYNC = 96,
    parameter int H_BACK = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT = 10,
    parameter int V_SYNC = 2,
    parameter int V_BACK = 33,
    parameter logic [5:0] KEY_COLOR = 6'b100001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic [5:0] overlay_rgb,
    input  logic [5:0] bg_rgb,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic [5:0] rgb_out,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic [7:0] fc_q, fc_d;
    logic [5:0] rgb_q, rgb_d;
    logic       hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic       h_wrap, v_wrap;
    always_comb begin
        h_wrap = h_q == 10'(H_TOTAL - 1);
        v_wrap = v_q == 10'(V_TOTAL - 1);
        h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d    = !h_wrap ? v_q : v_wrap ? 10'd0 : v_q + 10'd1;
        fc_d   = (h_wrap && v_wrap) ? fc_q + 8'd1 : fc_q;
        active = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
        // Blanking always forces black, even when the overlay presents the key colour.
        rgb_d  = !active ? 6'd0 : (overlay_rgb == KEY_COLOR) ? bg_rgb : overlay_rgb;
        hs_d   = !((h_q >= 10'(H_ACTIVE + H_FRONT)) && (h_q <= 10'(H_ACTIVE + H_FRONT + H_SYNC - 1)));
        vs_d   = !((v_q >= 10'(V_ACTIVE + V_FRONT)) && (v_q <= 10'(V_ACTIVE + V_FRONT + V_SYNC - 1)));
        fs_d   = (h_q == 10'd0) && (v_q == 10'd0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q   <= '0;
            v_q   <= '0;
            fc_q  <= '0;
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else if (pix_en) begin
            h_q   <= h_d;
            v_q   <= v_d;
            fc_q  <= fc_d;
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
        end
    end
    assign x           = h_q;
    assign y           = v_q;
    assign rgb_out     = rgb_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;
endmodule
